// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the five-stage CPU decode path.
// Holds default datapath widths, the MIPS-style opcode/funct encodings that the
// decoder recognises, and the ALU operation codes handed to the EX stage.
package cpu_defs_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_RADDR_W = 5;
    localparam int unsigned DEF_ALUOP_W = 8;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL = 6'h00,
        FN_SRL = 6'h02,
        FN_SRA = 6'h03,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_XOR = 6'h26,
        FN_NOR = 6'h27
    } funct_e;

    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_OR  = 8'h25;
    localparam logic [7:0] ALU_AND = 8'h24;
    localparam logic [7:0] ALU_XOR = 8'h26;
    localparam logic [7:0] ALU_NOR = 8'h27;
    localparam logic [7:0] ALU_SLL = 8'h7C;
    localparam logic [7:0] ALU_SRL = 8'h02;
    localparam logic [7:0] ALU_SRA = 8'h03;
    localparam logic [7:0] ALU_LW  = 8'hE3;

endpackage

// File: rtl/id_stage_if.sv
// ID/EX output bus of the decode stage.
//   out_valid / out_ready : valid/ready handshake towards EX
//   aluop_o, reg1_o, reg2_o, wreg_o, wd_o, is_load_o, illegal_o, pc_o : decoded payload
// master: driven by id_stage; slave: consumed by the EX stage.
interface id_stage_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned ALUOP_W = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [ALUOP_W-1:0] aluop_o;
    logic [DATA_W-1:0]  reg1_o;
    logic [DATA_W-1:0]  reg2_o;
    logic               wreg_o;
    logic [RADDR_W-1:0] wd_o;
    logic               is_load_o;
    logic               illegal_o;
    logic [31:0]        pc_o;

    modport master (
        output out_valid, aluop_o, reg1_o, reg2_o, wreg_o, wd_o, is_load_o, illegal_o, pc_o,
        input  out_ready
    );

    modport slave (
        input  out_valid, aluop_o, reg1_o, reg2_o, wreg_o, wd_o, is_load_o, illegal_o, pc_o,
        output out_ready
    );
endinterface

// File: rtl/id_decode.sv
// Purely combinational instruction decoder.
//   inst_i                    : instruction word
//   aluop_o                   : ALU operation code
//   reg1/2_read_o, _addr_o    : register-file read enables and addresses (rs, rt)
//   imm1_o / imm2_o           : value used for operand 1 / 2 when that port is not read
//   wd_o, wreg_o              : destination register and write enable (0 when wd is $0)
//   is_load_o, illegal_o      : load flag, unrecognised opcode/funct flag
module id_decode
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    parameter int unsigned ALUOP_W = DEF_ALUOP_W
) (
    input  logic [31:0]        inst_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               reg1_read_o,
    output logic               reg2_read_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    output logic [DATA_W-1:0]  imm1_o,
    output logic [DATA_W-1:0]  imm2_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic               is_load_o,
    output logic               illegal_o
);
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic        wr_en;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm   = inst_i[15:0];

    // Addresses are always driven from the instruction fields.
    assign reg1_addr_o = RADDR_W'(rs);
    assign reg2_addr_o = RADDR_W'(rt);

    always_comb begin
        aluop_o     = ALUOP_W'(ALU_NOP);
        reg1_read_o = 1'b0;
        reg2_read_o = 1'b0;
        imm1_o      = '0;
        imm2_o      = '0;
        wd_o        = '0;
        wr_en       = 1'b0;
        is_load_o   = 1'b0;
        illegal_o   = 1'b0;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                aluop_o     = (op == OP_ORI)  ? ALUOP_W'(ALU_OR)  :
                              (op == OP_ANDI) ? ALUOP_W'(ALU_AND) : ALUOP_W'(ALU_XOR);
                reg1_read_o = 1'b1;
                imm2_o      = DATA_W'(imm);
                wd_o        = RADDR_W'(rt);
                wr_en       = 1'b1;
            end
            OP_LUI: begin
                aluop_o = ALUOP_W'(ALU_OR);
                imm2_o  = DATA_W'({imm, 16'h0000});
                wd_o    = RADDR_W'(rt);
                wr_en   = 1'b1;
            end
            OP_LW: begin
                aluop_o     = ALUOP_W'(ALU_LW);
                reg1_read_o = 1'b1;
                imm2_o      = {{(DATA_W-16){imm[15]}}, imm};
                wd_o        = RADDR_W'(rt);
                wr_en       = 1'b1;
                is_load_o   = 1'b1;
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        aluop_o     = (funct == FN_AND) ? ALUOP_W'(ALU_AND) :
                                      (funct == FN_OR)  ? ALUOP_W'(ALU_OR)  :
                                      (funct == FN_XOR) ? ALUOP_W'(ALU_XOR) : ALUOP_W'(ALU_NOR);
                        reg1_read_o = 1'b1;
                        reg2_read_o = 1'b1;
                        wd_o        = RADDR_W'(rd);
                        wr_en       = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        aluop_o     = (funct == FN_SLL) ? ALUOP_W'(ALU_SLL) :
                                      (funct == FN_SRL) ? ALUOP_W'(ALU_SRL) : ALUOP_W'(ALU_SRA);
                        reg2_read_o = 1'b1;
                        imm1_o      = DATA_W'(sa);
                        wd_o        = RADDR_W'(rd);
                        wr_en       = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

    // Writes to $0 are suppressed so that 0x00000000 is a true NOP.
    assign wreg_o = wr_en && (wd_o != '0);

endmodule

// File: rtl/id_stage.sv
// Pipelined decode stage between IF/ID and EX.
//   clk, rst (async, active-low)
//   in_valid/in_ready, pc_i, inst_i          : instruction from IF/ID
//   reg1/2_addr_o, reg1/2_read_o, reg1/2_data_i : register-file read ports
//   ex_* / mem_*                             : EX and MEM result bypass
//   flush_i                                  : drop ID instruction and clear the output register
//   out_if (master)                          : registered ID/EX payload with valid/ready
module id_stage
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    parameter int unsigned ALUOP_W = DEF_ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        inst_i,
    output logic [RADDR_W-1:0] reg1_addr_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    output logic               reg1_read_o,
    output logic               reg2_read_o,
    input  logic [DATA_W-1:0]  reg1_data_i,
    input  logic [DATA_W-1:0]  reg2_data_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic               flush_i,
    id_stage_if.master         out_if
);
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_r1, dec_r2;
    logic [RADDR_W-1:0] dec_a1, dec_a2;
    logic [DATA_W-1:0]  dec_imm1, dec_imm2;
    logic [RADDR_W-1:0] dec_wd;
    logic               dec_wreg, dec_load, dec_illegal;

    id_decode #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .inst_i      (inst_i),
        .aluop_o     (dec_aluop),
        .reg1_read_o (dec_r1),
        .reg2_read_o (dec_r2),
        .reg1_addr_o (dec_a1),
        .reg2_addr_o (dec_a2),
        .imm1_o      (dec_imm1),
        .imm2_o      (dec_imm2),
        .wd_o        (dec_wd),
        .wreg_o      (dec_wreg),
        .is_load_o   (dec_load),
        .illegal_o   (dec_illegal)
    );

    assign reg1_addr_o = dec_a1;
    assign reg2_addr_o = dec_a2;
    assign reg1_read_o = dec_r1;
    assign reg2_read_o = dec_r2;

    // Registered ID/EX payload.
    logic               out_valid_q, out_valid_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [DATA_W-1:0]  reg1_q, reg1_d;
    logic [DATA_W-1:0]  reg2_q, reg2_d;
    logic               wreg_q, wreg_d;
    logic [RADDR_W-1:0] wd_q, wd_d;
    logic               is_load_q, is_load_d;
    logic               illegal_q, illegal_d;
    logic [31:0]        pc_q, pc_d;

    logic [DATA_W-1:0]  opnd1, opnd2;
    logic               stall, advance;

    // Operand select: unread port -> immediate, $0 -> 0, then EX, MEM, register file.
    always_comb begin
        if (!dec_r1)                             opnd1 = dec_imm1;
        else if (dec_a1 == '0)                   opnd1 = '0;
        else if (ex_wreg_i && ex_wd_i == dec_a1)   opnd1 = ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == dec_a1) opnd1 = mem_wdata_i;
        else                                     opnd1 = reg1_data_i;

        if (!dec_r2)                             opnd2 = dec_imm2;
        else if (dec_a2 == '0)                   opnd2 = '0;
        else if (ex_wreg_i && ex_wd_i == dec_a2)   opnd2 = ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == dec_a2) opnd2 = mem_wdata_i;
        else                                     opnd2 = reg2_data_i;
    end

    // A load in EX has no data yet; wait one cycle until it reaches MEM.
    assign stall = ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                   ((dec_r1 && ex_wd_i == dec_a1) || (dec_r2 && ex_wd_i == dec_a2));

    assign advance  = !out_valid_q || out_if.out_ready;
    // During a flush the ID instruction is consumed (and dropped) regardless of stall.
    assign in_ready = rst && (flush_i || (advance && !stall));

    always_comb begin
        out_valid_d = out_valid_q;
        aluop_d     = aluop_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        wreg_d      = wreg_q;
        wd_d        = wd_q;
        is_load_d   = is_load_q;
        illegal_d   = illegal_q;
        pc_d        = pc_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            // Empty input or stall leaves a bubble.
            out_valid_d = in_valid && !stall;
            if (in_valid && !stall) begin
                aluop_d   = dec_aluop;
                reg1_d    = opnd1;
                reg2_d    = opnd2;
                wreg_d    = dec_wreg;
                wd_d      = dec_wd;
                is_load_d = dec_load;
                illegal_d = dec_illegal;
                pc_d      = pc_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wreg_q      <= 1'b0;
            wd_q        <= '0;
            is_load_q   <= 1'b0;
            illegal_q   <= 1'b0;
            pc_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            aluop_q     <= aluop_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wreg_q      <= wreg_d;
            wd_q        <= wd_d;
            is_load_q   <= is_load_d;
            illegal_q   <= illegal_d;
            pc_q        <= pc_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.aluop_o   = aluop_q;
    assign out_if.reg1_o    = reg1_q;
    assign out_if.reg2_o    = reg2_q;
    assign out_if.wreg_o    = wreg_q;
    assign out_if.wd_o      = wd_q;
    assign out_if.is_load_o = is_load_q;
    assign out_if.illegal_o = illegal_q;
    assign out_if.pc_o      = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage.
module tb_id_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   pc_i, inst_i;
    logic [AW-1:0] reg1_addr_o, reg2_addr_o;
    logic          reg1_read_o, reg2_read_o;
    logic [DW-1:0] reg1_data_i, reg2_data_i;
    logic          ex_wreg_i, ex_is_load_i, mem_wreg_i, flush_i;
    logic [AW-1:0] ex_wd_i, mem_wd_i;
    logic [DW-1:0] ex_wdata_i, mem_wdata_i;
    logic          out_ready;

    id_stage_if #(.DATA_W(DW), .RADDR_W(AW), .ALUOP_W(OW)) bus ();
    assign bus.out_ready = out_ready;

    id_stage #(.DATA_W(DW), .RADDR_W(AW), .ALUOP_W(OW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .reg1_addr_o  (reg1_addr_o),
        .reg2_addr_o  (reg2_addr_o),
        .reg1_read_o  (reg1_read_o),
        .reg2_read_o  (reg2_read_o),
        .reg1_data_i  (reg1_data_i),
        .reg2_data_i  (reg2_data_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_is_load_i (ex_is_load_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .flush_i      (flush_i),
        .out_if       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rf1, rf2;
        logic        ex_wreg;
        logic [4:0]  ex_wd;
        logic [31:0] ex_wdata;
        logic        mem_wreg;
        logic [4:0]  mem_wd;
        logic [31:0] mem_wdata;
        logic [7:0]  e_aluop;
        logic [31:0] e_reg1, e_reg2;
        logic        e_wreg;
        logic [4:0]  e_wd;
        logic        e_load, e_ill;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        logic [31:0] inst, logic [31:0] rf1, logic [31:0] rf2,
        logic ex_wreg, logic [4:0] ex_wd, logic [31:0] ex_wdata,
        logic mem_wreg, logic [4:0] mem_wd, logic [31:0] mem_wdata,
        logic [7:0] e_aluop, logic [31:0] e_reg1, logic [31:0] e_reg2,
        logic e_wreg, logic [4:0] e_wd, logic e_load, logic e_ill);
        vec_t v;
        v.inst = inst; v.rf1 = rf1; v.rf2 = rf2;
        v.ex_wreg = ex_wreg; v.ex_wd = ex_wd; v.ex_wdata = ex_wdata;
        v.mem_wreg = mem_wreg; v.mem_wd = mem_wd; v.mem_wdata = mem_wdata;
        v.e_aluop = e_aluop; v.e_reg1 = e_reg1; v.e_reg2 = e_reg2;
        v.e_wreg = e_wreg; v.e_wd = e_wd; v.e_load = e_load; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        ex_wreg_i = 0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = '0; mem_wdata_i = '0;
    endtask

    initial begin
        // ORI, forwarding, $0, LUI, LW, illegal, shifts, NOP, XORI, NOR, ANDI, bad funct
        vecs.push_back(mk(32'h3421_1234, 32'hF0, 32'h0, 0, 0, 0, 0, 0, 0,
                          8'h25, 32'hF0, 32'h1234, 1, 1, 0, 0));
        vecs.push_back(mk(32'h0022_1825, 32'h1111, 32'h2222, 1, 1, 32'hAAAA, 1, 1, 32'h5555,
                          8'h25, 32'hAAAA, 32'h2222, 1, 3, 0, 0));
        vecs.push_back(mk(32'h0022_1825, 32'h1111, 32'h2222, 1, 1, 32'hAAAA, 1, 2, 32'h7777,
                          8'h25, 32'hAAAA, 32'h7777, 1, 3, 0, 0));
        vecs.push_back(mk(32'h0002_1825, 32'h1234, 32'h22, 1, 0, 32'hDEAD, 0, 0, 0,
                          8'h25, 32'h0, 32'h22, 1, 3, 0, 0));
        vecs.push_back(mk(32'h3C01_8000, 32'h5555, 32'h6666, 0, 0, 0, 0, 0, 0,
                          8'h25, 32'h0, 32'h8000_0000, 1, 1, 0, 0));
        vecs.push_back(mk(32'h8C22_FFFC, 32'h1000, 32'h0, 0, 0, 0, 0, 0, 0,
                          8'hE3, 32'h1000, 32'hFFFF_FFFC, 1, 2, 1, 0));
        vecs.push_back(mk(32'hFC22_1234, 32'h77, 32'h88, 0, 0, 0, 0, 0, 0,
                          8'h00, 32'h0, 32'h0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0002_2900, 32'h99, 32'h0F, 0, 0, 0, 0, 0, 0,
                          8'h7C, 32'h4, 32'h0F, 1, 5, 0, 0));
        vecs.push_back(mk(32'h0002_37C3, 32'h99, 32'h8000_0000, 0, 0, 0, 0, 0, 0,
                          8'h03, 32'h1F, 32'h8000_0000, 1, 6, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 32'h99, 32'h99, 0, 0, 0, 0, 0, 0,
                          8'h7C, 32'h0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h3867_FFFF, 32'h1234_5678, 32'h0, 0, 0, 0, 1, 3, 32'hCAFE,
                          8'h26, 32'hCAFE, 32'h0000_FFFF, 1, 7, 0, 0));
        vecs.push_back(mk(32'h0085_4027, 32'hA, 32'hB, 0, 0, 0, 0, 0, 0,
                          8'h27, 32'hA, 32'hB, 1, 8, 0, 0));
        vecs.push_back(mk(32'h3009_00FF, 32'h44, 32'h0, 0, 0, 0, 0, 0, 0,
                          8'h24, 32'h0, 32'hFF, 1, 9, 0, 0));
        vecs.push_back(mk(32'h0022_183F, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0,
                          8'h00, 32'h0, 32'h0, 0, 0, 0, 1));

        // Reset held with a valid instruction presented.
        rst = 0; in_valid = 1; inst_i = 32'h3421_1234; pc_i = 32'h40;
        reg1_data_i = '0; reg2_data_i = '0; flush_i = 0; out_ready = 1;
        clear_bypass();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_aluop", bus.aluop_o, 0);
        chk("rst_reg1", bus.reg1_o, 0);
        chk("rst_reg2", bus.reg2_o, 0);
        chk("rst_flags", {bus.wreg_o, bus.is_load_o, bus.illegal_o}, 0);
        chk("rst_wd_pc", {bus.wd_o, bus.pc_o}, 0);
        chk("rd_addr_comb", {reg1_addr_o, reg2_addr_o}, {5'd1, 5'd1});
        @(negedge clk);
        rst = 1;

        foreach (vecs[i]) begin
            inst_i = vecs[i].inst; pc_i = 32'h1000 + 32'(i) * 4;
            reg1_data_i = vecs[i].rf1; reg2_data_i = vecs[i].rf2;
            ex_wreg_i = vecs[i].ex_wreg; ex_wd_i = vecs[i].ex_wd; ex_wdata_i = vecs[i].ex_wdata;
            mem_wreg_i = vecs[i].mem_wreg; mem_wd_i = vecs[i].mem_wd;
            mem_wdata_i = vecs[i].mem_wdata;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_aluop", i), bus.aluop_o, vecs[i].e_aluop);
            chk($sformatf("v%0d_reg1", i), bus.reg1_o, vecs[i].e_reg1);
            chk($sformatf("v%0d_reg2", i), bus.reg2_o, vecs[i].e_reg2);
            chk($sformatf("v%0d_wreg_wd", i), {bus.wreg_o, bus.wd_o}, {vecs[i].e_wreg, vecs[i].e_wd});
            chk($sformatf("v%0d_load_ill", i), {bus.is_load_o, bus.illegal_o},
                {vecs[i].e_load, vecs[i].e_ill});
            chk($sformatf("v%0d_pc", i), bus.pc_o, 32'h1000 + 32'(i) * 4);
        end

        // Load-use: ori $5,$4,1 while lw $4 sits in EX.
        clear_bypass();
        inst_i = 32'h3485_0001; pc_i = 32'h2000; reg1_data_i = 32'h1;
        ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 4; ex_wdata_i = 32'hBAD;
        #1;
        chk("lu_stall_in_ready", in_ready, 0);
        tick();
        chk("lu_bubble", bus.out_valid, 0);
        clear_bypass();
        mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h4444;
        #1;
        chk("lu_release_in_ready", in_ready, 1);
        tick();
        chk("lu_valid", bus.out_valid, 1);
        chk("lu_reg1_mem_fwd", bus.reg1_o, 32'h4444);
        chk("lu_wd", bus.wd_o, 5);

        // Backpressure: hold 3 cycles, then andi $9 passes exactly once.
        clear_bypass();
        out_ready = 0; inst_i = 32'h3009_00FF; pc_i = 32'h2004; reg1_data_i = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
            tick();
            chk($sformatf("bp%0d_hold", k), {bus.out_valid, bus.wd_o, bus.reg1_o, bus.pc_o},
                {1'b1, 5'd5, 32'h4444, 32'h2000});
        end
        out_ready = 1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_next", {bus.out_valid, bus.wd_o, bus.reg2_o, bus.pc_o},
            {1'b1, 5'd9, 32'hFF, 32'h2004});
        in_valid = 0;
        tick();
        chk("bp_no_dup", bus.out_valid, 0);

        // Flush while a load-use stall is active.
        in_valid = 1; inst_i = 32'h3421_1234; pc_i = 32'h3000; reg1_data_i = 32'hF0;
        tick();
        chk("fl_pre_valid", bus.out_valid, 1);
        out_ready = 0; inst_i = 32'h3485_0001; pc_i = 32'h3004;
        ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 4; flush_i = 1;
        #1;
        chk("fl_in_ready", in_ready, 1);
        tick();
        chk("fl_cleared", bus.out_valid, 0);
        flush_i = 0; clear_bypass(); in_valid = 0; out_ready = 1;
        tick();
        chk("fl_dropped", bus.out_valid, 0);

        // Asynchronous reset mid-stream, then acceptance right after release.
        in_valid = 1; inst_i = 32'h3421_1234; pc_i = 32'h4000;
        tick();
        chk("ar_pre_valid", bus.out_valid, 1);
        #2;
        rst = 0;
        #1;
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_payload", {bus.aluop_o, bus.reg1_o, bus.pc_o}, 0);
        chk("ar_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("ar_release_in_ready", in_ready, 1);
        tick();
        chk("ar_first_accept", {bus.out_valid, bus.aluop_o, bus.pc_o}, {1'b1, 8'h25, 32'h4000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
